// File: rtl/day_count_ctrl.sv
// rtl/day_count_ctrl.sv - day-of-year counter with debounced key, auto-step, leap wrap and sequential BCD output
module day_count_ctrl #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int AUTO_DIV        = 10000000,
   parameter int CNT_W           = 24
) (
   input  logic       ADC_CLK_10,
   input  logic       rst_n,
   input  logic       key_inc_n,
   input  logic       auto_en,
   input  logic       leap,
   output logic [8:0] day_count,
   output logic [3:0] bcd_hund,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_ones,
   output logic       bcd_valid,
   output logic       wrap
);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} db_state_t;
   typedef enum logic [1:0] {B_IDLE, B_SHIFT, B_DONE} bcd_state_t;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_DIV - 1);

   logic             key_s1, key_s;
   logic             auto_s1, auto_s;
   logic             leap_s1, leap_s;
   db_state_t        db_state;
   logic [CNT_W-1:0] db_cnt;
   logic [CNT_W-1:0] auto_cnt;
   logic             inc_req;
   logic             auto_req;
   logic             step;
   logic [8:0]       day_max;
   bcd_state_t       bstate;
   logic [20:0]      sreg;
   logic [3:0]       bit_cnt;
   logic [8:0]       day_loaded;

   // One double-dabble iteration: correct each BCD nibble, then shift the whole register left.
   function automatic logic [20:0] dd_step(input logic [20:0] s);
      logic [20:0] t;
      t = s;
      for (int i = 0; i < 3; i++) begin
         if (t[9+4*i +: 4] >= 4'd5)
            t[9+4*i +: 4] = t[9+4*i +: 4] + 4'd3;
      end
      return {t[19:0], 1'b0};
   endfunction

   always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
      if (!rst_n) begin
         key_s1  <= 1'b1;
         key_s   <= 1'b1;
         auto_s1 <= 1'b0;
         auto_s  <= 1'b0;
         leap_s1 <= 1'b0;
         leap_s  <= 1'b0;
      end else begin
         key_s1  <= key_inc_n;
         key_s   <= key_s1;
         auto_s1 <= auto_en;
         auto_s  <= auto_s1;
         leap_s1 <= leap;
         leap_s  <= leap_s1;
      end
   end

   // Debounce: a press is accepted once, and the key must be stably released before the next one.
   always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
      if (!rst_n) begin
         db_state <= IDLE;
         db_cnt   <= '0;
         inc_req  <= 1'b0;
      end else begin
         inc_req <= 1'b0;
         case (db_state)
            IDLE: begin
               if (!key_s) begin
                  db_state <= PRESS_WAIT;
                  db_cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (key_s) begin
                  db_state <= IDLE;
               end else if (db_cnt == DB_LAST) begin
                  db_state <= HELD;
                  inc_req  <= 1'b1;
               end else begin
                  db_cnt <= db_cnt + 1'b1;
               end
            end
            HELD: begin
               if (key_s) begin
                  db_state <= REL_WAIT;
                  db_cnt   <= '0;
               end
            end
            REL_WAIT: begin
               if (!key_s) begin
                  db_state <= HELD;
               end else if (db_cnt == DB_LAST) begin
                  db_state <= IDLE;
               end else begin
                  db_cnt <= db_cnt + 1'b1;
               end
            end
            default: db_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
      if (!rst_n) begin
         auto_cnt <= '0;
         auto_req <= 1'b0;
      end else begin
         auto_req <= 1'b0;
         if (!auto_s) begin
            auto_cnt <= '0;
         end else if (auto_cnt == AUTO_LAST) begin
            auto_cnt <= '0;
            auto_req <= 1'b1;
         end else begin
            auto_cnt <= auto_cnt + 1'b1;
         end
      end
   end

   assign step    = inc_req | auto_req;
   assign day_max = leap_s ? 9'd366 : 9'd365;

   // ">=" rather than "==" so a 366 left behind by clearing leap still wraps on the next step.
   always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
      if (!rst_n) begin
         day_count <= 9'd1;
         wrap      <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (step) begin
            if (day_count >= day_max) begin
               day_count <= 9'd1;
               wrap      <= 1'b1;
            end else begin
               day_count <= day_count + 9'd1;
            end
         end
      end
   end

   // The step clears bcd_valid in the same edge day_count moves, so stale digits are never flagged valid.
   always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
      if (!rst_n) begin
         bstate     <= B_IDLE;
         sreg       <= '0;
         bit_cnt    <= '0;
         day_loaded <= 9'd1;
         bcd_hund   <= 4'd0;
         bcd_tens   <= 4'd0;
         bcd_ones   <= 4'd1;
         bcd_valid  <= 1'b1;
      end else begin
         if (day_count != day_loaded) begin
            sreg       <= {12'd0, day_count};
            day_loaded <= day_count;
            bit_cnt    <= '0;
            bcd_valid  <= 1'b0;
            bstate     <= B_SHIFT;
         end else begin
            case (bstate)
               B_IDLE: ;
               B_SHIFT: begin
                  sreg    <= dd_step(sreg);
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd8)
                     bstate <= B_DONE;
               end
               B_DONE: begin
                  bcd_hund  <= sreg[20:17];
                  bcd_tens  <= sreg[16:13];
                  bcd_ones  <= sreg[12:9];
                  bcd_valid <= 1'b1;
                  bstate    <= B_IDLE;
               end
               default: bstate <= B_IDLE;
            endcase
         end
         if (step)
            bcd_valid <= 1'b0;
      end
   end

endmodule
